// File: rtl/branch_resolver_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolver_pkg
// Shared CPU definitions for the branch resolver: condition-code encodings,
// flag-register bit positions and the resolver FSM state encoding.
// -----------------------------------------------------------------------------
package branch_resolver_pkg;

  // Flag-register bit positions
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  // Branch condition codes
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Resolver FSM states
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FLAGS = 2'd1,
    ST_RESP       = 2'd2
  } state_e;

endpackage

// File: rtl/branch_resolver_cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Purely combinational branch-condition evaluator.
//   cond  [3:0] : condition code (cond_e encoding)
//   flags [3:0] : flag register (Z, N, V, C at FLAG_* positions)
//   taken       : condition holds for the given flags
// -----------------------------------------------------------------------------
module cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic z, n, v, c;

  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];

  always_comb begin
    // NOTE: a default assigned before the case keeps this block latch-free
    // even if an arm is ever removed.
    taken = 1'b0;
    unique case (cond_e'(cond))
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !c || z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
// Accepts one branch request at a time, evaluates its condition against the
// flag register (waiting out any in-flight flag write), and returns the taken
// decision plus the next PC through a valid/ready response port. Keeps a
// saturating count of taken branches.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_cond/req_pc/req_offset : condition code, branch PC, signed offset
//   flags, flag_write_en       : flag register and "write in flight" marker
//   resp_valid/resp_ready      : response handshake
//   resp_taken/resp_target     : decision and next PC (zero when not valid)
//   taken_count                : saturating count of taken evaluations
// -----------------------------------------------------------------------------
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cond,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [3:0]        flags,
  input  logic              flag_write_en,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_taken,
  output logic [ADDR_W-1:0] resp_target,
  output logic [CNT_W-1:0]  taken_count
);

  state_e            state_q, state_d;
  logic [3:0]        cond_q, cond_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic              taken_q, taken_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              do_eval;
  logic [3:0]        eval_cond;
  logic [ADDR_W-1:0] eval_pc;
  logic [ADDR_W-1:0] eval_offset;
  logic              eval_taken;

  // Evaluation in IDLE uses the live request (latency-1 path); in WAIT_FLAGS
  // it uses the request captured at accept.
  assign eval_cond   = (state_q == ST_IDLE) ? req_cond   : cond_q;
  assign eval_pc     = (state_q == ST_IDLE) ? req_pc     : pc_q;
  assign eval_offset = (state_q == ST_IDLE) ? req_offset : offset_q;

  cond_eval u_cond_eval (
    .cond  (eval_cond),
    .flags (flags),
    .taken (eval_taken)
  );

  // Gated by rst_n so nothing looks acceptable while reset holds the FSM.
  assign req_ready   = (state_q == ST_IDLE) && rst_n;
  assign resp_valid  = (state_q == ST_RESP);
  // taken_q/target_q are cleared whenever RESP is left, so they read as zero
  // outside a valid response.
  assign resp_taken  = taken_q;
  assign resp_target = target_q;
  assign taken_count = count_q;

  always_comb begin
    state_d  = state_q;
    cond_d   = cond_q;
    pc_d     = pc_q;
    offset_d = offset_q;
    taken_d  = taken_q;
    target_d = target_q;
    count_d  = count_q;
    do_eval  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cond_d   = req_cond;
          pc_d     = req_pc;
          offset_d = req_offset;
          if (flag_write_en) state_d = ST_WAIT_FLAGS;
          else               do_eval = 1'b1;
        end
      end
      ST_WAIT_FLAGS: begin
        if (!flag_write_en) do_eval = 1'b1;
      end
      ST_RESP: begin
        // Returning to IDLE here means req_ready only rises next cycle.
        if (resp_ready) begin
          state_d  = ST_IDLE;
          taken_d  = 1'b0;
          target_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_eval) begin
      state_d  = ST_RESP;
      taken_d  = eval_taken;
      // Sum truncates to ADDR_W bits, giving modulo-2^ADDR_W wrap-around.
      target_d = eval_pc + (eval_taken ? eval_offset : ADDR_W'(1));
      if (eval_taken && (count_q != '1)) count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cond_q   <= '0;
      pc_q     <= '0;
      offset_q <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cond_q   <= cond_d;
      pc_q     <= pc_d;
      offset_q <= offset_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
// Self-checking bench for branch_resolver. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_cond = '0;
  logic [15:0] req_pc = '0;
  logic [15:0] req_offset = '0;
  logic [3:0]  flags = '0;
  logic        flag_write_en = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_taken;
  logic [15:0] resp_target;
  logic [7:0]  taken_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  branch_resolver #(.ADDR_W(16), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_cond      (req_cond),
    .req_pc        (req_pc),
    .req_offset    (req_offset),
    .flags         (flags),
    .flag_write_en (flag_write_en),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_taken    (resp_taken),
    .resp_target   (resp_target),
    .taken_count   (taken_count)
  );

  // Reference: conditions come in complementary pairs; even code = base
  // predicate, odd code = its inverse.
  function automatic logic ref_taken(input int c, input logic [3:0] f);
    bit z, n, v, cy;
    bit base [8];
    z = f[0]; n = f[1]; v = f[2]; cy = f[3];
    base[0] = z;
    base[1] = cy;
    base[2] = n;
    base[3] = v;
    base[4] = cy && !z;
    base[5] = (n == v);
    base[6] = !z && (n == v);
    base[7] = 1'b1;
    return base[c / 2] ^ bit'(c % 2);
  endfunction

  function automatic logic [15:0] ref_target(input int pc, input int off, input logic tk);
    return 16'((pc + (tk ? off : 1)) % 65536);
  endfunction

  function automatic void ref_count(input logic tk);
    if (tk && exp_cnt < 255) exp_cnt++;
  endfunction

  // Drives one request (entered 1 unit after a rising edge with the DUT idle),
  // optionally changes flags on the falling edge of the accept cycle, holds
  // flag_write_en for 'hold' extra cycles, waits (bounded) for the response
  // and consumes it. Reports what it observed; callers do the comparisons.
  task automatic run_branch(input logic [3:0] c, input logic [15:0] pc, off,
                            input logic fwe, input int hold,
                            input logic chg, input logic [3:0] nf,
                            output int lat, output logic tk, output logic [15:0] tg,
                            output logic rdy_during, output logic valid_after,
                            output logic rdy_after);
    req_valid = 1'b1; req_cond = c; req_pc = pc; req_offset = off;
    flag_write_en = fwe;
    if (chg) begin
      @(negedge clk);
      flags = nf;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    if (fwe) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        lat++;
      end
      flag_write_en = 1'b0;
    end
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    tk = resp_taken;
    tg = resp_target;
    rdy_during = req_ready;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    valid_after = resp_valid;
    rdy_after = req_ready;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end checks++;
    if (resp_taken !== 1'b0) begin errors++; $display("FAIL reset_resp_taken: got %b want 0", resp_taken); end checks++;
    if (resp_target !== 16'h0) begin errors++; $display("FAIL reset_resp_target: got %h want 0000", resp_target); end checks++;
    if (taken_count !== 8'h0) begin errors++; $display("FAIL reset_taken_count: got %0d want 0", taken_count); end checks++;
    #9 rst_n = 1'b1;
    exp_cnt = 0;
    @(posedge clk); #1;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end checks++;
  endtask

  task automatic test_eq_basic();
    int lat; logic tk, rd, va, ra; logic [15:0] tg;
    flags = 4'b0001;
    run_branch(4'h0, 16'h0010, 16'h0008, 1'b0, 0, 1'b0, 4'h0, lat, tk, tg, rd, va, ra);
    ref_count(1'b1);
    if (lat !== 1) begin errors++; $display("FAIL eq_latency: got %0d want 1", lat); end checks++;
    if (tk !== 1'b1) begin errors++; $display("FAIL eq_taken: got %b want 1", tk); end checks++;
    if (tg !== 16'h0018) begin errors++; $display("FAIL eq_target: got %h want 0018", tg); end checks++;
    if (taken_count !== 8'd1) begin errors++; $display("FAIL eq_count: got %0d want 1", taken_count); end checks++;
    if (rd !== 1'b0) begin errors++; $display("FAIL eq_ready_in_resp: got %b want 0", rd); end checks++;
    if (va !== 1'b0) begin errors++; $display("FAIL eq_valid_after: got %b want 0", va); end checks++;
    if (ra !== 1'b1) begin errors++; $display("FAIL eq_ready_after: got %b want 1", ra); end checks++;
  endtask

  task automatic test_flag_wait();
    int lat; logic tk, rd, va, ra; logic [15:0] tg, pc;
    pc = 16'($urandom);
    flags = 4'b0000;
    run_branch(4'h1, pc, 16'h0040, 1'b1, 0, 1'b1, 4'b0001, lat, tk, tg, rd, va, ra);
    if (lat !== 2) begin errors++; $display("FAIL wait_latency: got %0d want 2", lat); end checks++;
    if (tk !== 1'b0) begin errors++; $display("FAIL wait_taken: got %b want 0", tk); end checks++;
    if (tg !== ref_target(int'(pc), 0, 1'b0)) begin errors++; $display("FAIL wait_target: got %h want %h", tg, ref_target(int'(pc), 0, 1'b0)); end checks++;
    // A longer flag write keeps the resolver waiting.
    flags = 4'b0000;
    run_branch(4'h0, pc, 16'h0004, 1'b1, 3, 1'b1, 4'b0001, lat, tk, tg, rd, va, ra);
    ref_count(1'b1);
    if (lat !== 5) begin errors++; $display("FAIL wait_long_latency: got %0d want 5", lat); end checks++;
    if (tk !== 1'b1) begin errors++; $display("FAIL wait_long_taken: got %b want 1", tk); end checks++;
  endtask

  task automatic test_wrap();
    int lat; logic tk, rd, va, ra; logic [15:0] tg;
    flags = 4'($urandom);
    run_branch(4'hE, 16'hFFFE, 16'h0005, 1'b0, 0, 1'b0, 4'h0, lat, tk, tg, rd, va, ra);
    ref_count(1'b1);
    if (tg !== 16'h0003) begin errors++; $display("FAIL wrap_al_target: got %h want 0003", tg); end checks++;
    run_branch(4'hF, 16'hFFFF, 16'h1234, 1'b0, 0, 1'b0, 4'h0, lat, tk, tg, rd, va, ra);
    if (tk !== 1'b0) begin errors++; $display("FAIL wrap_nv_taken: got %b want 0", tk); end checks++;
    if (tg !== 16'h0000) begin errors++; $display("FAIL wrap_nv_target: got %h want 0000", tg); end checks++;
  endtask

  task automatic test_conditions();
    int lat, want_lat, hold; logic tk, rd, va, ra, fwe, want_tk; logic [15:0] tg, pc, off;
    logic [3:0] want_signed;
    want_signed = 4'b1010;  // conds A,B,C,D -> 0,1,0,1 (bit i = cond A+i)
    flags = 4'b0010;        // N=1, V=0
    for (int i = 0; i < 4; i++) begin
      run_branch(4'(10 + i), 16'h0100, 16'h0010, 1'b0, 0, 1'b0, 4'h0, lat, tk, tg, rd, va, ra);
      ref_count(tk === 1'b1);
      if (tk !== want_signed[i]) begin errors++; $display("FAIL signed_cond_%0h: got %b want %b", 10 + i, tk, want_signed[i]); end checks++;
    end
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        pc = 16'($urandom); off = 16'($urandom);
        fwe = 1'($urandom); hold = $urandom_range(0, 2);
        flags = 4'(f);
        want_tk = ref_taken(c, 4'(f));
        want_lat = fwe ? 2 + hold : 1;
        run_branch(4'(c), pc, off, fwe, hold, 1'b0, 4'h0, lat, tk, tg, rd, va, ra);
        ref_count(want_tk);
        if (tk !== want_tk) begin errors++; $display("FAIL cond_%0h_flags_%0h_taken: got %b want %b", c, f, tk, want_tk); end checks++;
        if (tg !== ref_target(int'(pc), int'(off), want_tk)) begin errors++; $display("FAIL cond_%0h_flags_%0h_target: got %h want %h", c, f, tg, ref_target(int'(pc), int'(off), want_tk)); end checks++;
        if (lat !== want_lat) begin errors++; $display("FAIL cond_%0h_flags_%0h_latency: got %0d want %0d", c, f, lat, want_lat); end checks++;
        if (int'(taken_count) !== exp_cnt) begin errors++; $display("FAIL cond_%0h_flags_%0h_count: got %0d want %0d", c, f, taken_count, exp_cnt); end checks++;
        if (va !== 1'b0 || ra !== 1'b1) begin errors++; $display("FAIL cond_%0h_flags_%0h_handoff: got valid %b ready %b want 0 1", c, f, va, ra); end checks++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pc, off, want_tg;
    pc = 16'($urandom); off = 16'($urandom);
    flags = 4'b1000;  // C=1, Z=0 -> HI taken
    want_tg = ref_target(int'(pc), int'(off), 1'b1);
    req_valid = 1'b1; req_cond = 4'h8; req_pc = pc; req_offset = off; flag_write_en = 1'b0;
    @(posedge clk); #1;
    ref_count(1'b1);
    // Keep offering a different request; it must not be taken.
    req_pc = ~pc;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b1 || resp_taken !== 1'b1 || resp_target !== want_tg || req_ready !== 1'b0)
        begin errors++; $display("FAIL stall_%0d: got valid %b taken %b target %h ready %b want 1 1 %h 0", i, resp_valid, resp_taken, resp_target, req_ready, want_tg); end
      checks++;
      flags = 4'($urandom);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    if (resp_valid !== 1'b0 || resp_target !== 16'h0 || resp_taken !== 1'b0) begin errors++; $display("FAIL stall_release: got valid %b taken %b target %h want 0 0 0000", resp_valid, resp_taken, resp_target); end checks++;
    if (int'(taken_count) !== exp_cnt) begin errors++; $display("FAIL stall_count: got %0d want %0d", taken_count, exp_cnt); end checks++;
  endtask

  task automatic test_saturation();
    int lat, bad; logic tk, rd, va, ra; logic [15:0] tg;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      run_branch(4'hE, 16'(i), 16'h0002, 1'b0, 0, 1'b0, 4'h0, lat, tk, tg, rd, va, ra);
      ref_count(1'b1);
      if (int'(taken_count) !== exp_cnt) bad++;
    end
    if (bad !== 0) begin errors++; $display("FAIL sat_track: got %0d mismatching steps want 0", bad); end checks++;
    if (taken_count !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d want 255", taken_count); end checks++;
  endtask

  task automatic test_async_reset();
    int lat, stale; logic tk, rd, va, ra; logic [15:0] tg;
    // Reset during WAIT_FLAGS.
    flags = 4'b0001;
    req_valid = 1'b1; req_cond = 4'h0; req_pc = 16'h0200; req_offset = 16'h0010; flag_write_en = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    if (resp_valid !== 1'b0 || resp_taken !== 1'b0 || resp_target !== 16'h0 || taken_count !== 8'h0 || req_ready !== 1'b0)
      begin errors++; $display("FAIL rst_wait_outputs: got valid %b taken %b target %h count %0d ready %b want all 0", resp_valid, resp_taken, resp_target, taken_count, req_ready); end
    checks++;
    exp_cnt = 0;
    #3 rst_n = 1'b1;
    flag_write_en = 1'b0;
    stale = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) stale++;
    end
    if (stale !== 0) begin errors++; $display("FAIL rst_wait_stale: got %0d valid cycles want 0", stale); end checks++;
    run_branch(4'h0, 16'h0300, 16'h0020, 1'b0, 0, 1'b0, 4'h0, lat, tk, tg, rd, va, ra);
    ref_count(1'b1);
    if (lat !== 1 || tk !== 1'b1 || tg !== 16'h0320) begin errors++; $display("FAIL rst_wait_next: got lat %0d taken %b target %h want 1 1 0320", lat, tk, tg); end checks++;

    // Reset during RESP.
    req_valid = 1'b1; req_cond = 4'hE; req_pc = 16'h0400; req_offset = 16'h0004;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (resp_valid !== 1'b1) begin errors++; $display("FAIL rst_resp_setup: got valid %b want 1", resp_valid); end checks++;
    #2 rst_n = 1'b0;
    #1;
    if (resp_valid !== 1'b0 || resp_taken !== 1'b0 || resp_target !== 16'h0 || taken_count !== 8'h0 || req_ready !== 1'b0)
      begin errors++; $display("FAIL rst_resp_outputs: got valid %b taken %b target %h count %0d ready %b want all 0", resp_valid, resp_taken, resp_target, taken_count, req_ready); end
    checks++;
    exp_cnt = 0;
    #1 rst_n = 1'b1;
    resp_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0) stale++;
    end
    resp_ready = 1'b0;
    if (stale !== 0) begin errors++; $display("FAIL rst_resp_stale: got %0d valid cycles want 0", stale); end checks++;
    flags = 4'b0000;
    run_branch(4'h3, 16'h0500, 16'h0030, 1'b0, 0, 1'b0, 4'h0, lat, tk, tg, rd, va, ra);
    ref_count(1'b1);
    if (lat !== 1 || tk !== 1'b1 || tg !== 16'h0530) begin errors++; $display("FAIL rst_resp_next: got lat %0d taken %b target %h want 1 1 0530", lat, tk, tg); end checks++;
    if (int'(taken_count) !== exp_cnt) begin errors++; $display("FAIL rst_resp_count: got %0d want %0d", taken_count, exp_cnt); end checks++;
  endtask

  initial begin
    test_reset();
    test_eq_basic();
    test_flag_wait();
    test_wrap();
    test_conditions();
    test_backpressure();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
